// File: rtl/stream_demux_pkt.sv
// Packet-aware valid/ready demultiplexer with one register stage per output.
// Optional statistics counters are enabled by defining STREAM_DEMUX_PKT_STATS_EN.
module stream_demux_pkt #(
   parameter int unsigned N_OUP      = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LOG_N_OUP  = (N_OUP > 1) ? $clog2(N_OUP) : 1
`ifdef STREAM_DEMUX_PKT_STATS_EN
   , parameter int unsigned CNT_WIDTH = 16
`endif
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 inp_valid_i,
   output logic                                 inp_ready_o,
   input  logic [DATA_WIDTH-1:0]                inp_data_i,
   input  logic                                 inp_last_i,
   input  logic [LOG_N_OUP-1:0]                 oup_sel_i,
   output logic [N_OUP-1:0]                     oup_valid_o,
   input  logic [N_OUP-1:0]                     oup_ready_i,
   output logic [N_OUP-1:0][DATA_WIDTH-1:0]     oup_data_o,
   output logic [N_OUP-1:0]                     oup_last_o,
   output logic                                 pkt_active_o,
   output logic                                 drop_o
`ifdef STREAM_DEMUX_PKT_STATS_EN
   , output logic [N_OUP-1:0][CNT_WIDTH-1:0]    pkt_cnt_o,
   output logic [CNT_WIDTH-1:0]                 drop_cnt_o
`endif
);

   typedef enum logic [1:0] {IDLE, LOCKED, DROP} state_e;

   state_e                           state_q, state_d;
   logic [LOG_N_OUP-1:0]             sel_q, sel_d, eff_sel;
   logic [N_OUP-1:0]                 valid_q, last_q, can_load, route_hit, load;
   logic [N_OUP-1:0][DATA_WIDTH-1:0] data_q;
   logic                             in_range, accept;

   assign eff_sel  = (state_q == LOCKED) ? sel_q : oup_sel_i;
   assign can_load = ~valid_q | oup_ready_i;

   // One-hot decode of the target; an all-zero vector means out of range.
   for (genvar k = 0; k < N_OUP; k++) begin : g_route
      if (N_OUP == 1) begin : g_single
         assign route_hit[k] = 1'b1;
      end else begin : g_multi
         assign route_hit[k] = (eff_sel == LOG_N_OUP'(k));
      end
   end

   assign in_range     = |route_hit;
   assign accept       = inp_valid_i & inp_ready_o;
   assign pkt_active_o = (state_q != IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      case (state_q)
         IDLE: begin
            if (inp_valid_i && !inp_last_i) begin
               if (!in_range) begin
                  state_d = DROP;
               end else if (accept) begin
                  state_d = LOCKED;
                  sel_d   = oup_sel_i;
               end
            end
         end
         LOCKED: if (accept && inp_last_i) state_d = IDLE;
         DROP:   if (inp_valid_i && inp_last_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Ready is derived from the target register only, never from inp_valid_i.
   always_comb begin
      inp_ready_o = 1'b1;
      drop_o      = 1'b0;
      load        = '0;
      if (state_q == DROP || !in_range) begin
         drop_o = inp_valid_i;
      end else begin
         inp_ready_o = |(route_hit & can_load);
         load        = route_hit & can_load & {N_OUP{inp_valid_i}};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
         last_q  <= '0;
         data_q  <= '0;
      end else begin
         for (int k = 0; k < N_OUP; k++) begin
            if (load[k]) begin
               valid_q[k] <= 1'b1;
               data_q[k]  <= inp_data_i;
               last_q[k]  <= inp_last_i;
            end else if (oup_ready_i[k]) begin
               valid_q[k] <= 1'b0;
            end
         end
      end
   end

   assign oup_valid_o = valid_q;
   assign oup_data_o  = data_q;
   assign oup_last_o  = last_q;

`ifdef STREAM_DEMUX_PKT_STATS_EN
   logic [N_OUP-1:0][CNT_WIDTH-1:0] pkt_cnt_q;
   logic [CNT_WIDTH-1:0]            drop_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         for (int k = 0; k < N_OUP; k++) begin
            if (load[k] && inp_last_i && !(&pkt_cnt_q[k])) begin
               pkt_cnt_q[k] <= pkt_cnt_q[k] + CNT_WIDTH'(1);
            end
         end
         if (drop_o && inp_last_i && !(&drop_cnt_q)) begin
            drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   assign pkt_cnt_o  = pkt_cnt_q;
   assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux_pkt.sv
// Bench for stream_demux_pkt: a 4-output and a 3-output instance, each checked
// every cycle against a packet-level reference model, plus directed vectors.
module tb_stream_demux_pkt;
   localparam int DW   = 32;
   localparam int CMAX = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          in_v [2];
   logic [DW-1:0] in_d [2];
   logic          in_l [2];
   logic [1:0]    in_s [2];
   logic [3:0]    o_rdy[2];

   logic                a_rdy, a_act, a_drop;
   logic [3:0]          a_ov, a_ol;
   logic [3:0][DW-1:0]  a_od;
   logic                b_rdy, b_act, b_drop;
   logic [2:0]          b_ov, b_ol;
   logic [2:0][DW-1:0]  b_od;
`ifdef STREAM_DEMUX_PKT_STATS_EN
   logic [3:0][1:0]     a_pc;
   logic [1:0]          a_dc;
   logic [2:0][1:0]     b_pc;
   logic [1:0]          b_dc;
`endif

   stream_demux_pkt #(.N_OUP(4), .DATA_WIDTH(DW)
`ifdef STREAM_DEMUX_PKT_STATS_EN
      , .CNT_WIDTH(2)
`endif
   ) u_dut4 (
      .clk_i(clk), .rst_i(rst),
      .inp_valid_i(in_v[0]), .inp_ready_o(a_rdy), .inp_data_i(in_d[0]),
      .inp_last_i(in_l[0]), .oup_sel_i(in_s[0]),
      .oup_valid_o(a_ov), .oup_ready_i(o_rdy[0]), .oup_data_o(a_od),
      .oup_last_o(a_ol), .pkt_active_o(a_act), .drop_o(a_drop)
`ifdef STREAM_DEMUX_PKT_STATS_EN
      , .pkt_cnt_o(a_pc), .drop_cnt_o(a_dc)
`endif
   );

   stream_demux_pkt #(.N_OUP(3), .DATA_WIDTH(DW)
`ifdef STREAM_DEMUX_PKT_STATS_EN
      , .CNT_WIDTH(2)
`endif
   ) u_dut3 (
      .clk_i(clk), .rst_i(rst),
      .inp_valid_i(in_v[1]), .inp_ready_o(b_rdy), .inp_data_i(in_d[1]),
      .inp_last_i(in_l[1]), .oup_sel_i(in_s[1]),
      .oup_valid_o(b_ov), .oup_ready_i(o_rdy[1][2:0]), .oup_data_o(b_od),
      .oup_last_o(b_ol), .pkt_active_o(b_act), .drop_o(b_drop)
`ifdef STREAM_DEMUX_PKT_STATS_EN
      , .pkt_cnt_o(b_pc), .drop_cnt_o(b_dc)
`endif
   );

   int tests = 0;
   int fails = 0;

   // Reference model: per-output one-entry buffers and the open packet's destination.
   bit            mv  [2][4];
   logic [DW-1:0] md  [2][4];
   bit            ml  [2][4];
   int            mdest[2];
   int            mpc [2][4];
   int            mdc [2];

   function automatic int nout(input int m);
      return (m == 0) ? 4 : 3;
   endfunction

   function automatic int dest_of(input int m);
      return (mdest[m] < 0) ? int'(in_s[m]) : mdest[m];
   endfunction

   function automatic bit exp_ready(input int m);
      int d = dest_of(m);
      if (d >= nout(m)) return 1'b1;
      return !mv[m][d] || o_rdy[m][d];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mdest[m] = -1;
         mdc[m]   = 0;
         for (int k = 0; k < 4; k++) begin
            mv[m][k] = 0; md[m][k] = '0; ml[m][k] = 0; mpc[m][k] = 0;
         end
      end
   endtask

   task automatic model_check(input int m);
      logic rdy, act, drp;
      logic [3:0] ov, ol;
      logic [3:0][DW-1:0] od;
      int d = dest_of(m);
      if (m == 0) begin
         rdy = a_rdy; act = a_act; drp = a_drop; ov = a_ov; ol = a_ol; od = a_od;
      end else begin
         rdy = b_rdy; act = b_act; drp = b_drop; ov = {1'b0, b_ov}; ol = {1'b0, b_ol};
         od = '0; od[2:0] = b_od;
      end
      chk($sformatf("m%0d_ready", m), rdy, exp_ready(m));
      chk($sformatf("m%0d_drop", m), drp, in_v[m] && (d >= nout(m)));
      chk($sformatf("m%0d_active", m), act, mdest[m] >= 0);
      for (int k = 0; k < nout(m); k++) begin
         chk($sformatf("m%0d_valid%0d", m, k), ov[k], mv[m][k]);
         if (mv[m][k]) begin
            chk($sformatf("m%0d_data%0d", m, k), od[k], md[m][k]);
            chk($sformatf("m%0d_last%0d", m, k), ol[k], ml[m][k]);
         end
`ifdef STREAM_DEMUX_PKT_STATS_EN
         chk($sformatf("m%0d_pktcnt%0d", m, k), (m == 0) ? a_pc[k] : b_pc[k], mpc[m][k]);
`endif
      end
`ifdef STREAM_DEMUX_PKT_STATS_EN
      chk($sformatf("m%0d_dropcnt", m), (m == 0) ? a_dc : b_dc, mdc[m]);
`endif
   endtask

   task automatic model_update(input int m);
      int d  = dest_of(m);
      bit ac = in_v[m] && exp_ready(m);
      for (int k = 0; k < nout(m); k++)
         if (mv[m][k] && o_rdy[m][k]) mv[m][k] = 0;
      if (ac && d < nout(m)) begin
         mv[m][d] = 1; md[m][d] = in_d[m]; ml[m][d] = in_l[m];
         if (in_l[m] && mpc[m][d] < CMAX) mpc[m][d]++;
      end
      if (ac && d >= nout(m) && in_l[m] && mdc[m] < CMAX) mdc[m]++;
      if (ac) mdest[m] = in_l[m] ? -1 : d;
   endtask

   task automatic tick_body();
      model_check(0);
      model_check(1);
      @(posedge clk);
      model_update(0);
      model_update(1);
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
      tick_body();
   endtask

   task automatic drive(input int m, input logic v, input logic [DW-1:0] d,
                        input logic l, input logic [1:0] s, input logic [3:0] r);
      in_v[m] = v; in_d[m] = d; in_l[m] = l; in_s[m] = s; o_rdy[m] = r;
   endtask

   task automatic idle_all();
      drive(0, 1'b0, '0, 1'b0, 2'd0, 4'hF);
      drive(1, 1'b0, '0, 1'b0, 2'd0, 4'hF);
   endtask

   task automatic do_reset();
      idle_all();
      rst = 1'b1;
      #2;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          v;
      logic [31:0] d;
      bit          l;
      logic [1:0]  s;
      logic [3:0]  r;
      bit          e_rdy;
      bit          e_act;
      logic [3:0]  e_ov;
      logic [3:0]  e_ol;
      int          port;
      logic [31:0] e_dat;
   } vec_t;

   vec_t tbl[9];

   function automatic vec_t mk(bit v, logic [31:0] d, bit l, logic [1:0] s, logic [3:0] r,
                               bit e_rdy, bit e_act, logic [3:0] e_ov, logic [3:0] e_ol,
                               int port, logic [31:0] e_dat);
      vec_t t;
      t.v = v; t.d = d; t.l = l; t.s = s; t.r = r; t.e_rdy = e_rdy; t.e_act = e_act;
      t.e_ov = e_ov; t.e_ol = e_ol; t.port = port; t.e_dat = e_dat;
      return t;
   endfunction

   int sat_exp[5];

   initial begin
      // 3-beat packet to output 2, then single-beat packets to outputs 0..3.
      tbl[0] = mk(1, 32'hA000_0001, 0, 2'd2, 4'hF, 1, 0, 4'b0000, 4'b0000, -1, '0);
      tbl[1] = mk(1, 32'hA000_0002, 0, 2'd0, 4'hF, 1, 1, 4'b0100, 4'b0000,  2, 32'hA000_0001);
      tbl[2] = mk(1, 32'hA000_0003, 1, 2'd1, 4'hF, 1, 1, 4'b0100, 4'b0000,  2, 32'hA000_0002);
      tbl[3] = mk(1, 32'hB000_0000, 1, 2'd0, 4'hF, 1, 0, 4'b0100, 4'b0100,  2, 32'hA000_0003);
      tbl[4] = mk(1, 32'hB000_0001, 1, 2'd1, 4'hF, 1, 0, 4'b0001, 4'b0001,  0, 32'hB000_0000);
      tbl[5] = mk(1, 32'hB000_0002, 1, 2'd2, 4'hF, 1, 0, 4'b0010, 4'b0010,  1, 32'hB000_0001);
      tbl[6] = mk(1, 32'hB000_0003, 1, 2'd3, 4'hF, 1, 0, 4'b0100, 4'b0100,  2, 32'hB000_0002);
      tbl[7] = mk(0, 32'h0,         0, 2'd0, 4'hF, 1, 0, 4'b1000, 4'b1000,  3, 32'hB000_0003);
      tbl[8] = mk(0, 32'h0,         0, 2'd0, 4'hF, 1, 0, 4'b0000, 4'b0000, -1, '0);
      sat_exp = '{1, 2, 3, 3, 3};

      rst = 1'b1;
      idle_all();
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      chk("rst_valid_a", a_ov, 4'b0);
      chk("rst_data_a", |a_od, 1'b0);
      chk("rst_last_a", a_ol, 4'b0);
      chk("rst_active_a", a_act, 1'b0);
      chk("rst_drop_a", a_drop, 1'b0);
      chk("rst_valid_b", b_ov, 3'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) begin
         drive(0, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].s, tbl[i].r);
         @(negedge clk);
         chk($sformatf("vec%0d_ready", i), a_rdy, tbl[i].e_rdy);
         chk($sformatf("vec%0d_active", i), a_act, tbl[i].e_act);
         chk($sformatf("vec%0d_valid", i), a_ov, tbl[i].e_ov);
         chk($sformatf("vec%0d_last", i), a_ol & a_ov, tbl[i].e_ol);
         if (tbl[i].port >= 0)
            chk($sformatf("vec%0d_data", i), a_od[tbl[i].port], tbl[i].e_dat);
         tick_body();
      end

      // Output 1 stalled and full: a beat to 1 blocks the following beat to 3.
      drive(0, 1, 32'hC000_0000, 1, 2'd1, 4'b1101);
      tick();
      drive(0, 1, 32'hC000_0001, 1, 2'd1, 4'b1101);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_stall_ready", a_rdy, 1'b0);
         chk("bp_hold_data", a_od[1], 32'hC000_0000);
         tick_body();
      end
      drive(0, 1, 32'hC000_0001, 1, 2'd1, 4'hF);
      tick();
      drive(0, 1, 32'hC000_0002, 1, 2'd3, 4'hF);
      @(negedge clk);
      chk("bp_second_on_1", {a_ov[1], a_od[1]}, {1'b1, 32'hC000_0001});
      tick_body();
      idle_all();
      @(negedge clk);
      chk("bp_third_on_3", {a_ov[3], a_od[3]}, {1'b1, 32'hC000_0002});
      tick_body();

      // Three-output instance: two-beat packet to select 3 is dropped.
      drive(1, 1, 32'hD000_0000, 0, 2'd3, 4'hF);
      @(negedge clk);
      chk("drop1_ready", b_rdy, 1'b1);
      chk("drop1_pulse", b_drop, 1'b1);
      tick_body();
      drive(1, 1, 32'hD000_0001, 1, 2'd0, 4'hF);
      @(negedge clk);
      chk("drop2_pulse", b_drop, 1'b1);
      chk("drop2_active", b_act, 1'b1);
      tick_body();
      idle_all();
      @(negedge clk);
      chk("drop_no_valid", b_ov, 3'b0);
      chk("drop_idle", b_act, 1'b0);
`ifdef STREAM_DEMUX_PKT_STATS_EN
      chk("drop_cnt", b_dc, 2'd1);
`endif
      tick_body();

      // Reset while a packet is open and output 0 holds a beat.
      drive(0, 1, 32'hE000_0000, 0, 2'd0, 4'b1110);
      tick();
      idle_all();
      o_rdy[0] = 4'b1110;
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_valid", a_ov, 4'b0);
      chk("midrst_active", a_act, 1'b0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      drive(0, 1, 32'hE000_0002, 1, 2'd1, 4'hF);
      tick();
      idle_all();
      @(negedge clk);
      chk("postrst_route", {a_ov, a_od[1]}, {4'b0010, 32'hE000_0002});
      tick_body();

`ifdef STREAM_DEMUX_PKT_STATS_EN
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 32'hF000_0000 + i, 1, 2'd0, 4'hF);
         tick();
         chk($sformatf("sat_pkt%0d", i), a_pc[0], sat_exp[i]);
      end
      idle_all();
`endif

      do_reset();
      for (int i = 0; i < 3000; i++) begin
         for (int m = 0; m < 2; m++)
            drive(m, ($urandom % 10) < 7, $urandom, ($urandom % 3) == 0,
                  2'($urandom % 4), 4'($urandom));
         tick();
      end
      idle_all();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/stream_demux_pkt.md
Name: stream_demux_pkt

Overview:
- Packet-aware, registered successor to the plain valid/ready stream demultiplexer.
- Routes a data stream with a last-beat marker to one of N_OUP outputs. The output is selected on the first beat of each packet and locked until the last beat.
- Each output has its own one-entry full-throughput register stage.
- Out-of-range selects are sunk and dropped.
- Sits between a packet source (e.g. a network-on-chip ingress) and per-destination consumers.

Parameters:
- N_OUP, 4: number of outputs, >= 1.
- DATA_WIDTH, 32: width of the data payload.
- LOG_N_OUP, (N_OUP > 1) ? $clog2(N_OUP) : 1: width of the select. Dependent; do not override.
- CNT_WIDTH, 16: width of the statistics counters. Used only with STREAM_DEMUX_PKT_STATS_EN.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- inp_valid_i  in  1  input beat valid.
- inp_ready_o  out  1  input beat accepted.
- inp_data_i  in  DATA_WIDTH  input payload.
- inp_last_i  in  1  final beat of the packet.
- oup_sel_i  in  LOG_N_OUP  target output. Sampled only on the first beat of a packet.
- oup_valid_o  out  N_OUP  per-output valid.
- oup_ready_i  in  N_OUP  per-output ready.
- oup_data_o  out  N_OUP x DATA_WIDTH  per-output payload.
- oup_last_o  out  N_OUP  per-output last marker.
- pkt_active_o  out  1  high while a multi-beat packet is open (state LOCKED or DROP).
- drop_o  out  1  one-cycle pulse for each dropped beat.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, all oup_valid_o = 0, oup_data_o = 0, oup_last_o = 0.
  - pkt_active_o = 0, drop_o = 0.
- Handshake:
  - Transfer occurs when valid & ready are both high on a rising edge.
  - inp_ready_o never depends combinationally on inp_valid_i.
  - Once output k asserts oup_valid_o[k], it holds valid, data and last stable until oup_ready_i[k].
- Per-output register k:
  - can_load[k] = !valid_q[k] | oup_ready_i[k].
  - Loads data and last on an accepted beat routed to k.
  - valid_q[k] is set on load. It is cleared on an output handshake with no simultaneous load.
  - Input-to-output latency is 1 cycle. Throughput is 1 beat/cycle per output.
- Effective select:
  - eff_sel = oup_sel_i in IDLE; sel_q in LOCKED.
  - Out of range means eff_sel >= N_OUP. This is only possible when N_OUP is not a power of 2.
- State IDLE:
  - In range: inp_ready_o = can_load[eff_sel].
  - Accepted beat with !inp_last_i: sel_q <= oup_sel_i, go to LOCKED.
  - Accepted beat with inp_last_i (single-beat packet): stay in IDLE.
  - Out of range: inp_ready_o = 1 and the beat is discarded. drop_o = 1 in the same cycle if inp_valid_i is high.
  - Out of range with !inp_last_i: go to DROP.
- State LOCKED:
  - oup_sel_i is ignored. inp_ready_o = can_load[sel_q].
  - Accepted beat with inp_last_i: go to IDLE.
  - The next beat may start a new packet to any output with no bubble.
- State DROP:
  - inp_ready_o = 1. Every valid beat is discarded and drop_o = inp_valid_i.
  - Valid beat with inp_last_i: go to IDLE.
- Simultaneous events:
  - A load and an output handshake on the same output in the same cycle keep valid_q = 1 with the new data.
  - Handshakes on other outputs proceed independently.
- Backpressure: a stalled output k blocks the input only while the current beat targets k. Other outputs keep draining.
- N_OUP == 1: the select is ignored and no drops occur.
- Reset mid-packet: all buffered beats are discarded and the block returns to IDLE. The next beat is treated as a first beat.

Optional Feature:
- STREAM_DEMUX_PKT_STATS_EN defined:
  - Adds output port pkt_cnt_o (N_OUP x CNT_WIDTH): packets per output, incremented on each accepted last beat routed to that output.
  - Adds output port drop_cnt_o (CNT_WIDTH): incremented on each dropped last beat.
  - All counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- N_OUP=4, 3-beat packet with sel=2 on beat 1 and sel=0/1 on beats 2-3 -> all 3 beats appear on output 2, one cycle after acceptance, with oup_last_o[2] on beat 3. pkt_active_o is high after beat 1 until beat 3 is accepted.
- Back-to-back single-beat packets to sel 0,1,2,3 with all ready -> inp_ready_o stays 1, each output shows one beat one cycle later, and there are no bubbles.
- oup_ready_i[1]=0 with output 1 full, then a beat to sel=1 followed by a beat to sel=3 -> inp_ready_o=0 and the input stalls. After ready[1]=1, both beats are delivered in order and output 3 is unaffected.
- N_OUP=3, 2-beat packet with sel=3 -> inp_ready_o=1, drop_o pulses twice, no output is valid, state returns to IDLE. With STREAM_DEMUX_PKT_STATS_EN, drop_cnt_o increments by 1.
- Assert rst_i mid-packet, with output 0 holding a beat -> oup_valid_o=0 and pkt_active_o=0 immediately. After release, a beat with sel=1 routes to output 1.
- STREAM_DEMUX_PKT_STATS_EN, CNT_WIDTH=2: send 5 packets to output 0 -> pkt_cnt_o[0] reads 1,2,3,3,3.
